branch_adder: RTL and testbench

- Computes the branch/jump target `pc + (imm_out << 1)` for the processor's fetch/branch-resolution path. The immediate arrives from the immediate generator and is already sign-extended, in half-word units.
- Primary result `sum` is purely combinational, so the target is usable in the same cycle.
- A registered copy and status flags are provided for pipeline-stage use, clocked by the single core clock.

---
 rtl/branch_adder.sv | 44 ++++
 tb/tb_branch_adder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/branch_adder.sv
// Branch/jump target adder: combinational pc + (imm_out << SHIFT) with a
// registered copy plus alignment and carry flags for the next pipeline stage.
module branch_adder #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm_out,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] sum_q,
    output logic             valid_q,
    output logic             misaligned_q,
    output logic             carry_q
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   sum_ext;

    // Upper SHIFT bits of the immediate fall off the top; the sum wraps mod 2^WIDTH.
    assign shifted = imm_out << SHIFT;
    assign sum_ext = {1'b0, pc} + {1'b0, shifted};
    assign sum     = sum_ext[WIDTH-1:0];

    // Registered stage: rst wins over en, so a same-edge capture is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q        <= '0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            carry_q      <= 1'b0;
        end else if (en) begin
            sum_q        <= sum;
            valid_q      <= 1'b1;
            misaligned_q <= (sum[1:0] != 2'b00);
            carry_q      <= sum_ext[WIDTH];
        end else begin
            valid_q      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_adder.sv
// Directed and random checks for branch_adder: combinational target,
// captured copy, flags, reset priority and enable hold.
module tb_branch_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] imm_out;
    logic        en;
    logic [31:0] sum;
    logic [31:0] sum_q;
    logic        valid_q;
    logic        misaligned_q;
    logic        carry_q;

    int total  = 0;
    int passed = 0;

    branch_adder #(.WIDTH(32), .SHIFT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .imm_out      (imm_out),
        .en           (en),
        .sum          (sum),
        .sum_q        (sum_q),
        .valid_q      (valid_q),
        .misaligned_q (misaligned_q),
        .carry_q      (carry_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector, check sum with no clock, capture it, check registered outputs.
    task automatic apply(input string tag, input logic [31:0] p, input logic [31:0] i,
                         input logic [31:0] exp_sum, input logic exp_mis, input logic exp_c);
        pc      = p;
        imm_out = i;
        #1;
        check({tag, ".sum"}, sum, exp_sum);
        en = 1'b1;
        tick();
        en = 1'b0;
        check({tag, ".sum_q"}, sum_q, exp_sum);
        check({tag, ".valid_q"}, {31'd0, valid_q}, 32'd1);
        check({tag, ".misaligned_q"}, {31'd0, misaligned_q}, {31'd0, exp_mis});
        check({tag, ".carry_q"}, {31'd0, carry_q}, {31'd0, exp_c});
    endtask

    initial begin
        logic [31:0] rp, ri, rexp;
        rst = 1'b1; en = 1'b0; pc = '0; imm_out = '0;
        tick();
        tick();
        check("rst.sum_q", sum_q, 32'h0);
        check("rst.valid_q", {31'd0, valid_q}, 32'd0);
        check("rst.misaligned_q", {31'd0, misaligned_q}, 32'd0);
        check("rst.carry_q", {31'd0, carry_q}, 32'd0);
        rst = 1'b0;

        apply("fwd",   32'h0000_1000, 32'h0000_0004, 32'h0000_1008, 1'b0, 1'b0);
        tick();
        check("fwd.valid_drop", {31'd0, valid_q}, 32'd0);
        check("fwd.sum_q_hold", sum_q, 32'h0000_1008);

        apply("back",  32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0FF8, 1'b0, 1'b1);
        apply("far",   32'h1000_0000, 32'h0000_1000, 32'h1000_2000, 1'b0, 1'b0);
        apply("maxp",  32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
        apply("msb",   32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
        apply("zero",  32'h2000_0000, 32'h0000_0000, 32'h2000_0000, 1'b0, 1'b0);
        apply("odd",   32'h1234_5678, 32'h0000_ABCD, 32'h1235_AE12, 1'b1, 1'b0);
        apply("wrap",  32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0010, 1'b0, 1'b1);

        // Random combinational sweep, no clock edges involved.
        for (int k = 0; k < 20; k++) begin
            rp = $urandom;
            ri = $urandom;
            rexp = rp + {ri[30:0], 1'b0};
            pc = rp;
            imm_out = ri;
            #1;
            check("rand.sum", sum, rexp);
        end

        // Reset beats a simultaneous capture.
        pc = 32'h1234_5678; imm_out = 32'h0000_ABCD;
        rst = 1'b1; en = 1'b1;
        tick();
        check("rst_en.sum_q", sum_q, 32'h0);
        check("rst_en.valid_q", {31'd0, valid_q}, 32'd0);
        check("rst_en.misaligned_q", {31'd0, misaligned_q}, 32'd0);
        check("rst_en.carry_q", {31'd0, carry_q}, 32'd0);

        // Enable low: sum tracks inputs, registered outputs hold.
        rst = 1'b0; en = 1'b0;
        pc = 32'h0000_4000; imm_out = 32'hFFFF_FFFF;
        tick();
        check("hold.sum", sum, 32'h0000_3FFE);
        check("hold.sum_q", sum_q, 32'h0);
        check("hold.valid_q", {31'd0, valid_q}, 32'd0);
        pc = 32'h8000_0000; imm_out = 32'h4000_0000;
        tick();
        check("hold2.sum", sum, 32'h0000_0000);
        check("hold2.sum_q", sum_q, 32'h0);
        check("hold2.carry_q", {31'd0, carry_q}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
